scariv_l2_req_rr_arbiter: RTL and testbench

- Downstream of the LSU top. Merges the L1D external request streams (MSHR refill reads, store-requestor writes/evictions, and future sources such as a PTW or ICache port) into one L2 request channel.
- Uses round-robin arbitration with a registered one-entry output stage.
- Prefixes each request tag with the source index, routes L2 responses back by that index, and enforces a per-source outstanding-request limit.

---
 rtl/scariv_l2_req_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_scariv_l2_req_rr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_l2_req_rr_arbiter.sv
// Round-robin merge of L1D external request streams into one registered L2 request channel,
// with source-indexed tags, response routing back to the source, and per-source credit limits.
module scariv_l2_req_rr_arbiter #(
    parameter int ARB_NUM   = 2,
    parameter int PAYLOAD_W = 600,
    parameter int TAG_W     = 4,
    parameter int RESP_W    = 512,
    parameter int MAX_OUTST = 4,
    parameter int SRC_W     = $clog2(ARB_NUM)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [ARB_NUM-1:0]         i_req_valid,
    output logic [ARB_NUM-1:0]         o_req_ready,
    input  logic [ARB_NUM*PAYLOAD_W-1:0] i_req_payload,
    input  logic [ARB_NUM*TAG_W-1:0]   i_req_tag,
    output logic                       o_l2_req_valid,
    input  logic                       i_l2_req_ready,
    output logic [PAYLOAD_W-1:0]       o_l2_req_payload,
    output logic [SRC_W+TAG_W-1:0]     o_l2_req_tag,
    input  logic                       i_l2_resp_valid,
    input  logic [SRC_W+TAG_W-1:0]     i_l2_resp_tag,
    input  logic [RESP_W-1:0]          i_l2_resp_payload,
    output logic [ARB_NUM-1:0]         o_resp_valid,
    output logic [TAG_W-1:0]           o_resp_tag,
    output logic [RESP_W-1:0]          o_resp_payload,
    output logic                       o_idle,
    output logic                       o_err
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic                   buf_valid;
    logic [PAYLOAD_W-1:0]   buf_payload;
    logic [SRC_W+TAG_W-1:0] buf_tag;
    logic [SRC_W-1:0]       rr_ptr;
    logic                   err;
    logic [CNT_W-1:0]       cnt [ARB_NUM];

    logic [ARB_NUM-1:0]     eligible;
    logic [ARB_NUM-1:0]     cnt_zero;
    logic [2*ARB_NUM-1:0]   elig_dbl;
    logic [ARB_NUM-1:0]     elig_rot;
    logic                   grant_valid;
    logic [SRC_W-1:0]       grant_off;
    logic [SRC_W:0]         grant_sum;
    logic [SRC_W:0]         grant_wrap;
    logic [SRC_W-1:0]       grant_idx;
    logic [SRC_W-1:0]       ptr_next;
    logic                   accept;
    logic [PAYLOAD_W-1:0]   sel_payload;
    logic [TAG_W-1:0]       sel_tag;

    logic [SRC_W-1:0]       resp_src;
    logic                   resp_src_ok;
    logic [ARB_NUM-1:0]     inc;
    logic [ARB_NUM-1:0]     dec;
    logic                   resp_err;

    always_comb begin
        for (int s = 0; s < ARB_NUM; s++) begin
            cnt_zero[s] = (cnt[s] == '0);
            eligible[s] = i_req_valid[s] && (cnt[s] < CNT_W'(MAX_OUTST));
        end
    end

    // Rotate so bit 0 is the pointer position; the lowest set bit is the next source in RR order.
    assign elig_dbl = {eligible, eligible} >> rr_ptr;
    assign elig_rot = elig_dbl[ARB_NUM-1:0];

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_off   = '0;
        for (int i = ARB_NUM - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                grant_valid = 1'b1;
                grant_off   = SRC_W'(i);
            end
        end
    end

    always_comb begin
        grant_sum  = {1'b0, rr_ptr} + {1'b0, grant_off};
        grant_wrap = grant_sum - (SRC_W+1)'(ARB_NUM);
        grant_idx  = (grant_sum >= (SRC_W+1)'(ARB_NUM)) ? grant_wrap[SRC_W-1:0]
                                                        : grant_sum[SRC_W-1:0];
        ptr_next   = (grant_idx == SRC_W'(ARB_NUM - 1)) ? '0 : grant_idx + SRC_W'(1);
    end

    assign accept = grant_valid && (!buf_valid || i_l2_req_ready) && !i_reset;

    always_comb begin
        sel_payload = '0;
        sel_tag     = '0;
        for (int s = 0; s < ARB_NUM; s++) begin
            if (grant_idx == SRC_W'(s)) begin
                sel_payload = i_req_payload[s*PAYLOAD_W +: PAYLOAD_W];
                sel_tag     = i_req_tag[s*TAG_W +: TAG_W];
            end
        end
    end

    assign resp_src    = i_l2_resp_tag[TAG_W +: SRC_W];
    assign resp_src_ok = ({1'b0, resp_src} < (SRC_W+1)'(ARB_NUM));

    always_comb begin
        for (int s = 0; s < ARB_NUM; s++) begin
            o_req_ready[s]  = accept && (grant_idx == SRC_W'(s));
            o_resp_valid[s] = !i_reset && i_l2_resp_valid && resp_src_ok && (resp_src == SRC_W'(s));
        end
    end

    assign inc      = o_req_ready & i_req_valid;
    assign dec      = o_resp_valid;
    assign resp_err = i_l2_resp_valid && (!resp_src_ok || |(dec & cnt_zero));

    // NOTE: state updates use non-blocking assignments; the small counter array is reset
    // explicitly because credit accounting must restart from zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_valid   <= 1'b0;
            buf_payload <= '0;
            buf_tag     <= '0;
            rr_ptr      <= '0;
            err         <= 1'b0;
            for (int s = 0; s < ARB_NUM; s++) cnt[s] <= '0;
        end else begin
            if (accept) begin
                buf_valid   <= 1'b1;
                buf_payload <= sel_payload;
                buf_tag     <= {grant_idx, sel_tag};
                rr_ptr      <= ptr_next;
            end else if (buf_valid && i_l2_req_ready) begin
                buf_valid <= 1'b0;
            end
            for (int s = 0; s < ARB_NUM; s++) begin
                if (inc[s] && !dec[s]) begin
                    cnt[s] <= cnt[s] + CNT_W'(1);
                end else if (dec[s] && !inc[s] && !cnt_zero[s]) begin
                    cnt[s] <= cnt[s] - CNT_W'(1);
                end
            end
            if (resp_err) err <= 1'b1;
        end
    end

    assign o_l2_req_valid   = buf_valid;
    assign o_l2_req_payload = buf_payload;
    assign o_l2_req_tag     = buf_tag;
    assign o_resp_tag       = i_l2_resp_tag[TAG_W-1:0];
    assign o_resp_payload   = i_l2_resp_payload;
    assign o_idle           = !buf_valid && (&cnt_zero);
    assign o_err            = err;

endmodule

// File: tb/tb_scariv_l2_req_rr_arbiter.sv
// Directed bench for scariv_l2_req_rr_arbiter: a 2-source instance for the main scenarios
// and a 3-source instance for three-way rotation and out-of-range response sources.
module tb_scariv_l2_req_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 2-source instance
    logic [1:0]  a_req_valid;
    logic [1:0]  a_req_ready;
    logic [63:0] a_req_payload;
    logic [7:0]  a_req_tag;
    logic        a_l2_valid;
    logic        a_l2_ready;
    logic [31:0] a_l2_payload;
    logic [4:0]  a_l2_tag;
    logic        a_rsp_in_valid;
    logic [4:0]  a_rsp_in_tag;
    logic [31:0] a_rsp_in_payload;
    logic [1:0]  a_resp_valid;
    logic [3:0]  a_resp_tag;
    logic [31:0] a_resp_payload;
    logic        a_idle;
    logic        a_err;

    // 3-source instance
    logic [2:0]  b_req_valid;
    logic [2:0]  b_req_ready;
    logic [95:0] b_req_payload;
    logic [11:0] b_req_tag;
    logic        b_l2_valid;
    logic        b_l2_ready;
    logic [31:0] b_l2_payload;
    logic [5:0]  b_l2_tag;
    logic        b_rsp_in_valid;
    logic [5:0]  b_rsp_in_tag;
    logic [31:0] b_rsp_in_payload;
    logic [2:0]  b_resp_valid;
    logic [3:0]  b_resp_tag;
    logic [31:0] b_resp_payload;
    logic        b_idle;
    logic        b_err;

    scariv_l2_req_rr_arbiter #(
        .ARB_NUM(2), .PAYLOAD_W(32), .TAG_W(4), .RESP_W(32), .MAX_OUTST(4)
    ) dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_payload(a_req_payload), .i_req_tag(a_req_tag),
        .o_l2_req_valid(a_l2_valid), .i_l2_req_ready(a_l2_ready),
        .o_l2_req_payload(a_l2_payload), .o_l2_req_tag(a_l2_tag),
        .i_l2_resp_valid(a_rsp_in_valid), .i_l2_resp_tag(a_rsp_in_tag),
        .i_l2_resp_payload(a_rsp_in_payload),
        .o_resp_valid(a_resp_valid), .o_resp_tag(a_resp_tag), .o_resp_payload(a_resp_payload),
        .o_idle(a_idle), .o_err(a_err)
    );

    scariv_l2_req_rr_arbiter #(
        .ARB_NUM(3), .PAYLOAD_W(32), .TAG_W(4), .RESP_W(32), .MAX_OUTST(4)
    ) dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_payload(b_req_payload), .i_req_tag(b_req_tag),
        .o_l2_req_valid(b_l2_valid), .i_l2_req_ready(b_l2_ready),
        .o_l2_req_payload(b_l2_payload), .o_l2_req_tag(b_l2_tag),
        .i_l2_resp_valid(b_rsp_in_valid), .i_l2_resp_tag(b_rsp_in_tag),
        .i_l2_resp_payload(b_rsp_in_payload),
        .o_resp_valid(b_resp_valid), .o_resp_tag(b_resp_tag), .o_resp_payload(b_resp_payload),
        .o_idle(b_idle), .o_err(b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        a_req_valid = '0; a_req_payload = '0; a_req_tag = '0; a_l2_ready = 1'b1;
        a_rsp_in_valid = 1'b0; a_rsp_in_tag = '0; a_rsp_in_payload = '0;
        b_req_valid = '0; b_req_payload = '0; b_req_tag = '0; b_l2_ready = 1'b1;
        b_rsp_in_valid = 1'b0; b_rsp_in_tag = '0; b_rsp_in_payload = '0;
    endtask

    task automatic apply_reset;
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req_valid = 2'b11; a_rsp_in_valid = 1'b1; a_rsp_in_tag = 5'h00;
        #1;
        total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", a_req_ready); end
        total++; if (a_resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b want 00", a_resp_valid); end
        tick();
        total++; if (a_l2_valid !== 1'b0) begin bad++; $display("FAIL reset_l2_valid: got %b want 0", a_l2_valid); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", a_idle); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", a_err); end
        total++; if (a_l2_tag !== 5'h00) begin bad++; $display("FAIL reset_tag: got %h want 00", a_l2_tag); end
        quiet();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_round_robin;
        apply_reset();
        a_l2_ready  = 1'b1;
        a_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic       exp_src;
            logic [1:0] exp_rdy;
            logic [3:0] exp_tag;
            logic [31:0] exp_pl;
            exp_src = (i % 2) == 1;
            exp_rdy = exp_src ? 2'b10 : 2'b01;
            exp_tag = exp_src ? 4'(i + 8) : 4'(i);
            exp_pl  = exp_src ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i);
            a_req_tag     = {4'(i + 8), 4'(i)};
            a_req_payload = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
            #1;
            total++; if (a_req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, a_req_ready, exp_rdy); end
            tick();
            total++; if (a_l2_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", i, a_l2_valid); end
            total++; if (a_l2_tag !== {exp_src, exp_tag}) begin bad++; $display("FAIL rr_tag[%0d]: got %h want %h", i, a_l2_tag, {exp_src, exp_tag}); end
            total++; if (a_l2_payload !== exp_pl) begin bad++; $display("FAIL rr_payload[%0d]: got %h want %h", i, a_l2_payload, exp_pl); end
        end
        quiet();
    endtask

    task automatic test_backpressure;
        apply_reset();
        a_l2_ready = 1'b1;
        a_req_valid = 2'b01; a_req_payload = {32'h0, 32'h1111_0001}; a_req_tag = 8'h01;
        #1;
        total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL bp_first_ready: got %b want 01", a_req_ready); end
        tick();
        a_l2_ready    = 1'b0;
        a_req_valid   = 2'b11;
        a_req_payload = {32'h2222_0003, 32'h1111_0002};
        a_req_tag     = 8'h32;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 00", i, a_req_ready); end
            tick();
            total++; if (a_l2_payload !== 32'h1111_0001) begin bad++; $display("FAIL bp_hold_payload[%0d]: got %h want 11110001", i, a_l2_payload); end
            total++; if (a_l2_tag !== 5'h01) begin bad++; $display("FAIL bp_hold_tag[%0d]: got %h want 01", i, a_l2_tag); end
        end
        a_l2_ready = 1'b1;
        #1;
        total++; if (a_req_ready !== 2'b10) begin bad++; $display("FAIL bp_release_ready: got %b want 10", a_req_ready); end
        tick();
        total++; if (a_l2_payload !== 32'h2222_0003) begin bad++; $display("FAIL bp_next_payload: got %h want 22220003", a_l2_payload); end
        total++; if (a_l2_tag !== 5'h13) begin bad++; $display("FAIL bp_next_tag: got %h want 13", a_l2_tag); end
        a_req_valid = 2'b00;
        tick();
        total++; if (a_l2_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", a_l2_valid); end
        total++; if (a_idle !== 1'b0) begin bad++; $display("FAIL bp_not_idle: got %b want 0", a_idle); end
        quiet();
    endtask

    task automatic test_credit_limit;
        apply_reset();
        a_l2_ready = 1'b1;
        a_req_valid = 2'b01; a_req_payload = {32'h0, 32'h0000_0C0C}; a_req_tag = 8'h06;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL credit_fill[%0d]: got %b want 01", i, a_req_ready); end
            tick();
        end
        a_req_valid = 2'b11;
        tick();
        total++; if (a_req_ready !== 2'b10) begin bad++; $display("FAIL credit_skip: got %b want 10", a_req_ready); end
        a_req_valid = 2'b01;
        #1;
        total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL credit_blocked: got %b want 00", a_req_ready); end
        a_rsp_in_valid = 1'b1; a_rsp_in_tag = 5'h05; a_rsp_in_payload = 32'hCAFE_0005;
        #1;
        total++; if (a_resp_valid !== 2'b01) begin bad++; $display("FAIL credit_resp_valid: got %b want 01", a_resp_valid); end
        total++; if (a_resp_tag !== 4'h5) begin bad++; $display("FAIL credit_resp_tag: got %h want 5", a_resp_tag); end
        total++; if (a_resp_payload !== 32'hCAFE_0005) begin bad++; $display("FAIL credit_resp_payload: got %h want cafe0005", a_resp_payload); end
        total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL credit_same_cycle: got %b want 00", a_req_ready); end
        tick();
        a_rsp_in_valid = 1'b0;
        #1;
        total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL credit_regained: got %b want 01", a_req_ready); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL credit_err: got %b want 0", a_err); end
        quiet();
    endtask

    task automatic test_simultaneous;
        apply_reset();
        a_l2_ready = 1'b1;
        a_req_valid = 2'b10; a_req_tag = 8'h90;
        tick();
        tick();
        a_rsp_in_valid = 1'b1; a_rsp_in_tag = 5'h17;
        #1;
        total++; if (a_req_ready !== 2'b10) begin bad++; $display("FAIL sim_ready: got %b want 10", a_req_ready); end
        total++; if (a_resp_valid !== 2'b10) begin bad++; $display("FAIL sim_resp_valid: got %b want 10", a_resp_valid); end
        tick();
        a_req_valid = 2'b00;
        tick();
        a_rsp_in_valid = 1'b0;
        total++; if (a_idle !== 1'b0) begin bad++; $display("FAIL sim_one_left: got %b want 0", a_idle); end
        a_rsp_in_valid = 1'b1;
        tick();
        a_rsp_in_valid = 1'b0;
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL sim_idle: got %b want 1", a_idle); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL sim_err: got %b want 0", a_err); end
        quiet();
    endtask

    task automatic test_underflow;
        apply_reset();
        a_rsp_in_valid = 1'b1; a_rsp_in_tag = 5'h02;
        #1;
        total++; if (a_resp_valid !== 2'b01) begin bad++; $display("FAIL uf_resp_valid: got %b want 01", a_resp_valid); end
        tick();
        a_rsp_in_valid = 1'b0;
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL uf_err: got %b want 1", a_err); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL uf_idle: got %b want 1", a_idle); end
        a_req_valid = 2'b01;
        #1;
        total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL uf_not_wrapped: got %b want 01", a_req_ready); end
        tick();
        a_req_valid = 2'b00;
        tick();
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", a_err); end
        quiet();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        a_l2_ready = 1'b1;
        a_req_valid = 2'b01; a_req_tag = 8'h0A;
        tick();
        tick();
        a_l2_ready  = 1'b0;
        a_req_valid = 2'b11;
        #1;
        total++; if (a_l2_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", a_l2_valid); end
        rst = 1'b1;
        #1;
        total++; if (a_l2_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", a_l2_valid); end
        total++; if (a_idle !== 1'b1) begin bad++; $display("FAIL mid_idle: got %b want 1", a_idle); end
        total++; if (a_req_ready !== 2'b00) begin bad++; $display("FAIL mid_ready: got %b want 00", a_req_ready); end
        tick();
        rst = 1'b0;
        a_l2_ready = 1'b1;
        #1;
        total++; if (a_req_ready !== 2'b01) begin bad++; $display("FAIL mid_first_grant: got %b want 01", a_req_ready); end
        tick();
        total++; if (a_l2_tag !== 5'h0A) begin bad++; $display("FAIL mid_first_tag: got %h want 0a", a_l2_tag); end
        quiet();
    endtask

    task automatic test_three_sources;
        apply_reset();
        b_l2_ready = 1'b1;
        b_req_valid = 3'b111; b_req_tag = 12'h321;
        for (int i = 0; i < 3; i++) begin
            logic [2:0] exp_rdy;
            exp_rdy = 3'b001 << i;
            #1;
            total++; if (b_req_ready !== exp_rdy) begin bad++; $display("FAIL three_ready[%0d]: got %b want %b", i, b_req_ready, exp_rdy); end
            tick();
        end
        b_req_valid = 3'b000;
        b_rsp_in_valid = 1'b1; b_rsp_in_tag = 6'h32;
        #1;
        total++; if (b_resp_valid !== 3'b000) begin bad++; $display("FAIL bad_src_dropped: got %b want 000", b_resp_valid); end
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL bad_src_err_before: got %b want 0", b_err); end
        tick();
        b_rsp_in_valid = 1'b0;
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL bad_src_err: got %b want 1", b_err); end
        total++; if (b_idle !== 1'b0) begin bad++; $display("FAIL bad_src_cnt_kept: got %b want 0", b_idle); end
        quiet();
    endtask

    initial begin
        quiet();
        #2;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_credit_limit();
        test_simultaneous();
        test_underflow();
        test_reset_mid();
        test_three_sources();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
